// File: rtl/chdr_sid_filter_pkg.sv
// chdr_sid_filter_pkg: shared definitions for the SID filter.
//   - state_e : packet-level state (expecting header / forwarding / dropping)
//   - CTRL_*  : bit positions inside the CTRL settings register
//   - rule_val_off / rule_mask_off : settings-bus offsets (from SR_BASE) of
//     the value and mask registers of rule k
package chdr_sid_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_MODE_BIT    = 1;  // 0 = allow-list, 1 = deny-list
  localparam int CTRL_RULE_EN_LSB = 2;  // rule k enable at CTRL_RULE_EN_LSB + k

  function automatic int rule_val_off(input int k);
    return 1 + 2 * k;
  endfunction

  function automatic int rule_mask_off(input int k);
    return 2 + 2 * k;
  endfunction

endpackage

// File: rtl/chdr_sid_filter_axi_fifo.sv
// axi_fifo: 2**SIZE entry synchronous FIFO with valid/ready on both sides.
//   clk_i, rst_i, clear_i : clock, sync reset, sync flush (both empty it)
//   in_*                  : write side; in_ready_o = not full
//   out_*                 : read side; out_data_o is the head entry and stays
//                           stable until it is popped
// SIZE must be >= 1.
module axi_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int DEPTH = 1 << SIZE;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on the pointers distinguishes full from empty.
  logic [SIZE:0]    wr_ptr_q, wr_ptr_d;
  logic [SIZE:0]    rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;

  assign full  = (wr_ptr_q[SIZE] != rd_ptr_q[SIZE]) &&
                 (wr_ptr_q[SIZE-1:0] == rd_ptr_q[SIZE-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = in_valid_i && !full;
  assign pop   = !empty && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[SIZE-1:0]] <= in_data_i;
  end

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_data_o  = mem_q[rd_ptr_q[SIZE-1:0]];

endmodule

// File: rtl/chdr_sid_filter_setting_reg.sv
// setting_reg: one settings-bus register.
//   clk_i, rst_i     : clock, synchronous active-high reset (to AT_RESET)
//   stb_i, addr_i    : write strobe and 8-bit address; write when addr_i == ADDR
//   data_i           : 32-bit write data, low WIDTH bits are kept
//   data_o           : current register value
module setting_reg #(
  parameter int               ADDR     = 0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stb_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [7:0] ADDR8 = ADDR[7:0];

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                           data_q <= AT_RESET;
    else if (stb_i && (addr_i == ADDR8)) data_q <= data_i[WIDTH-1:0];
  end

  assign data_o = data_q;

  // Narrow registers ignore the upper write-data bits.
  if (WIDTH < 32) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^data_i[31:WIDTH];
  end

endmodule

// File: rtl/chdr_sid_filter.sv
// chdr_sid_filter: per-packet SID filter for CHDR/AXI-Stream.
// The SID (i_tdata[31:0] of the header beat) is matched against NUM_RULES
// value/mask rules; in allow-list mode a hit accepts, in deny-list mode a
// hit drops. Accepted packets go through an output FIFO; dropped packets
// are consumed at line rate regardless of o_tready.
//   clk, reset, clear        : clock, sync reset (everything), sync clear
//                              (FSM, counters, FIFO; settings kept)
//   set_stb/set_addr/set_data: settings bus (CTRL at SR_BASE, rules above)
//   i_t*                     : input stream
//   o_t*                     : output stream
//   pass_count, drop_count   : saturating packet counters
// WIDTH must be >= 32, NUM_RULES in 1..8.
module chdr_sid_filter
  import chdr_sid_filter_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_RULES = 4,
  parameter int SR_BASE   = 0,
  parameter int FIFO_SIZE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      pass_count,
  output logic [15:0]      drop_count
);

  localparam int CTRL_W = CTRL_RULE_EN_LSB + NUM_RULES;

  logic [CTRL_W-1:0]              ctrl;
  logic [NUM_RULES-1:0][31:0]     rule_val;
  logic [NUM_RULES-1:0][31:0]     rule_mask;
  logic [NUM_RULES-1:0]           hit;
  logic                           any_hit, hdr_accept, fwd, hs;
  logic                           fifo_in_ready;
  state_e                         state_q;
  logic [15:0]                    pass_q, drop_q;

  // ---- settings ----
  setting_reg #(.ADDR(SR_BASE), .WIDTH(CTRL_W), .AT_RESET('0)) u_ctrl (
    .clk_i(clk), .rst_i(reset), .stb_i(set_stb), .addr_i(set_addr),
    .data_i(set_data), .data_o(ctrl)
  );

  for (genvar k = 0; k < NUM_RULES; k++) begin : g_rule
    setting_reg #(.ADDR(SR_BASE + rule_val_off(k)), .WIDTH(32), .AT_RESET('0)) u_val (
      .clk_i(clk), .rst_i(reset), .stb_i(set_stb), .addr_i(set_addr),
      .data_i(set_data), .data_o(rule_val[k])
    );
    setting_reg #(.ADDR(SR_BASE + rule_mask_off(k)), .WIDTH(32), .AT_RESET('0)) u_mask (
      .clk_i(clk), .rst_i(reset), .stb_i(set_stb), .addr_i(set_addr),
      .data_i(set_data), .data_o(rule_mask[k])
    );
    assign hit[k] = ctrl[CTRL_RULE_EN_LSB + k] &&
                    (((i_tdata[31:0] ^ rule_val[k]) & rule_mask[k]) == 32'h0);
  end

  // ---- verdict (only meaningful on the header beat, i.e. in IDLE) ----
  assign any_hit    = |hit;
  assign hdr_accept = !ctrl[CTRL_EN_BIT] ||
                      (ctrl[CTRL_MODE_BIT] ? !any_hit : any_hit);

  // In IDLE the forward decision comes straight from i_tdata, which is the
  // documented combinational i_tdata -> i_tready path.
  assign fwd      = (state_q == ST_IDLE) ? hdr_accept : (state_q == ST_ACCEPT);
  assign i_tready = fwd ? fifo_in_ready : 1'b1;
  assign hs       = i_tvalid && i_tready;

  // ---- FSM + counters ----
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (hs) begin
          if (hdr_accept) begin
            if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
          end else begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
          end
          if (!i_tlast) state_q <= hdr_accept ? ST_ACCEPT : ST_DISCARD;
        end
        ST_ACCEPT, ST_DISCARD: if (hs && i_tlast) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pass_count = pass_q;
  assign drop_count = drop_q;

  // ---- output buffer ----
  // clear blocks the write so a beat handshaken in the clear cycle is lost.
  axi_fifo #(.WIDTH(WIDTH + 1), .SIZE(FIFO_SIZE)) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (clear),
    .in_data_i  ({i_tlast, i_tdata}),
    .in_valid_i (i_tvalid && fwd && !clear),
    .in_ready_o (fifo_in_ready),
    .out_data_o ({o_tlast, o_tdata}),
    .out_valid_o(o_tvalid),
    .out_ready_i(o_tready)
  );

endmodule

// File: doc/chdr_sid_filter.md
# chdr_sid_filter

Parametrised SID filter for CHDR/AXI-Stream packet streams, the successor to the fixed two-SID discard filter. It classifies each packet on its header beat against a bank of programmable value/mask rules in allow-list or deny-list mode. It forwards or silently discards whole packets and keeps saturating pass and drop counters. It sits on crossbar and radio ingress ports, ahead of packet consumers that must never see foreign SIDs.

## Interface
- WIDTH, 64: data width; must be ≥ 32.
- NUM_RULES, 4: number of value/mask rules, 1..8.
- SR_BASE, 0: settings-bus base address.
- FIFO_SIZE, 1: log2 depth of the output buffer.
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high; returns the whole block to reset state.
- clear  in  1  synchronous, active-high; resets state machine, counters and buffer; rules and control are kept.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  WIDTH  input beat; SID is i_tdata[31:0] on the header beat.
- i_tlast  in  1  last beat of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output beat.
- o_tlast  out  1  output last.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- pass_count  out  16  packets forwarded; saturates at 16'hFFFF.
- drop_count  out  16  packets discarded; saturates at 16'hFFFF.

## Operation
- Register SR_BASE+0 (CTRL), reset value 0:
  - bit0 filter_en.
  - bit1 mode: 0 = allow-list, 1 = deny-list.
  - bits[2+k] = rule k enable.
- Register SR_BASE+1+2k is RULE_VAL[k]; register SR_BASE+2+2k is RULE_MASK[k]. Both reset to 0.
- Writes to unmapped addresses are ignored.
- Rule k hits when it is enabled and ((SID ^ RULE_VAL[k]) & RULE_MASK[k]) == 0.
- any_hit = OR over all rules.
- Header verdict:
  - filter_en = 0: accept.
  - Allow-list: accept = any_hit.
  - Deny-list: accept = !any_hit.
- States:
  - IDLE, expecting a header. Verdict is computed combinationally from the current i_tdata.
  - On a header handshake with i_tlast = 0: go to ACCEPT or DISCARD.
  - On a header handshake with i_tlast = 1: stay in IDLE.
  - ACCEPT: forward beats; return to IDLE on a handshake with i_tlast.
  - DISCARD: consume beats; return to IDLE on a handshake with i_tlast.
- Forwarded beats (accepted header and the ACCEPT body) are written into the output buffer. Discarded beats are never written.
- i_tready:
  - Beat being forwarded: equals the buffer's input ready.
  - Beat being discarded: 1. Discard runs at line rate regardless of downstream backpressure.
- Counters:
  - pass_count increments on an accepted header handshake.
  - drop_count increments on a discarded header handshake.
  - Both saturate, never wrap.
- Reset values: state IDLE, counters 0, o_tvalid 0, CTRL and all rules 0. With filter_en = 0, every packet passes.

## Timing
- The verdict is fixed at the header handshake. Settings writes in the same cycle, or mid-packet, take effect on the next header only.
- Combinational path i_tdata → i_tready exists in IDLE only. It is documented and accepted.
- Latency from input handshake to o_tvalid: 1 cycle when the buffer is empty.
- Full throughput of 1 beat/cycle when o_tready = 1.
- When the buffer is full, forwarded beats stall and discarded beats still flow.
- o_tdata and o_tlast are held stable while o_tvalid = 1 and o_tready = 0.
- clear or reset mid-packet:
  - The buffer is flushed and the state returns to IDLE.
  - The next input beat is treated as a header; upstream is responsible for realignment.
  - Counters read 0 on the following cycle.
- Simultaneous clear and header handshake: clear wins; the beat is neither counted nor stored.

## Structure
- Shared package `chdr_sid_filter_pkg` holds:
  - state encodings IDLE/ACCEPT/DISCARD;
  - CTRL bit offsets;
  - the register offset functions for RULE_VAL and RULE_MASK.
- Rule registers use one setting_reg per register, generated over NUM_RULES.
- Output buffering is a single sub-module: axi_fifo with WIDTH+1 bits and SIZE = FIFO_SIZE.

## Test plan
- After reset, with no writes: 3 packets with SIDs 0x00A0, 0x1234, 0xFFFF → all forwarded bit-exact; pass_count = 3, drop_count = 0.
- Allow-list, rule0 = 0x00A0/0xFFFF and rule1 = 0x00B0/0xFFFF enabled, filter_en = 1; packets SID 0x00A0, 0x00C0, 0x00B0 → first and third forwarded; drop_count = 1.
- Deny-list with rule0 = 0x0100/0xFF00; SIDs 0x0105 and 0x0205 → 0x0105 dropped, 0x0205 forwarded.
- o_tready held 0 while a 10-beat bad-SID packet arrives → i_tready stays 1 and all beats are consumed; a following good packet stalls once the buffer is full and is forwarded intact after o_tready = 1.
- Single-beat packets (i_tlast on header), alternating good and bad, back-to-back → correct forwarding at 1 beat/cycle; state remains IDLE.
- Mid-packet rule rewrite, then 70000 bad packets, then clear asserted mid-packet → the in-flight packet keeps its verdict; drop_count saturates at 0xFFFF; after clear both counters are 0 and o_tvalid = 0.
